// File: rtl/vec_chk_pkg.sv
// Shared types and constants for the vector-replay checker.
package vec_chk_pkg;

  localparam int unsigned FAIL_CNT_W = 16;
  localparam int unsigned MAX_LAT    = 15;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StRun,
    StDrain,
    StDone
  } chk_state_e;

  function automatic logic [FAIL_CNT_W-1:0] sat_inc(input logic [FAIL_CNT_W-1:0] v);
    return (&v) ? v : v + FAIL_CNT_W'(1);
  endfunction

endpackage

// File: rtl/vec_chk_dly.sv
// Expected-response delay line: LAT stages of {valid, payload}; clr drops every valid bit.
module vec_chk_dly
  import vec_chk_pkg::*;
#(
  parameter int unsigned LAT = 1,
  parameter int unsigned DW  = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  // Out-of-range latency is clamped so the line is never zero-length.
  localparam int unsigned Stages = (LAT < 1) ? 1 : ((LAT > MAX_LAT) ? MAX_LAT : LAT);

  logic [Stages-1:0] vld_q;
  logic [DW-1:0]     data_q [Stages];

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_q <= '0;
    end else begin
      vld_q <= (vld_q << 1) | Stages'(in_valid);
    end
  end

  always_ff @(posedge clk) begin
    data_q[0] <= in_data;
    for (int i = 1; i < Stages; i++) begin
      data_q[i] <= data_q[i-1];
    end
  end

  assign out_valid = vld_q[Stages-1];
  assign out_data  = data_q[Stages-1];

endmodule

// File: rtl/vec_replay_chk.sv
// Vector-replay checker: streams ROM vectors into a DUT and compares responses after LAT edges.
// Define VEC_CHK_MASK_EN to add the mem_mask don't-care port.
module vec_replay_chk
  import vec_chk_pkg::*;
#(
  parameter int unsigned STIM_W = 49,
  parameter int unsigned RESP_W = 25,
  parameter int unsigned DEPTH  = 1500,
  parameter int unsigned LAT    = 1,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop_on_fail,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [STIM_W-1:0]     mem_stim,
  input  logic [RESP_W-1:0]     mem_resp,
`ifdef VEC_CHK_MASK_EN
  input  logic [RESP_W-1:0]     mem_mask,
`endif
  output logic [STIM_W-1:0]     dut_stim,
  input  logic [RESP_W-1:0]     dut_resp,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [FAIL_CNT_W-1:0] fail_cnt,
  output logic [15:0]           first_fail_idx,
  output logic [RESP_W-1:0]     first_fail_act
);

  localparam int unsigned IDX_W = 16;
`ifdef VEC_CHK_MASK_EN
  localparam int unsigned DW = IDX_W + 2 * RESP_W;
`else
  localparam int unsigned DW = IDX_W + RESP_W;
`endif
  localparam logic [IDX_W-1:0]  LastIdx  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  chk_state_e            state_q;
  logic [ADDR_W-1:0]     addr_q, addr_nxt;
  logic [IDX_W-1:0]      ld_idx_q;
  logic                  sof_q;
  logic [STIM_W-1:0]     stim_q;
  logic                  busy_q, done_q, pass_q;
  logic [FAIL_CNT_W-1:0] fail_cnt_q;
  logic [IDX_W-1:0]      ff_idx_q;
  logic [RESP_W-1:0]     ff_act_q;

  logic [DW-1:0]     push_data, dly_data;
  logic              dly_valid, push, mismatch, halt, dly_clr;
  logic [IDX_W-1:0]  cmp_idx;
  logic [RESP_W-1:0] cmp_exp, cmp_mask;

`ifdef VEC_CHK_MASK_EN
  assign push_data = {ld_idx_q, mem_resp, mem_mask};
  assign {cmp_idx, cmp_exp, cmp_mask} = dly_data;
`else
  assign push_data = {ld_idx_q, mem_resp};
  assign {cmp_idx, cmp_exp} = dly_data;
  assign cmp_mask  = '0;
`endif

  assign mismatch = dly_valid && (state_q == StRun || state_q == StDrain) &&
                    |((dut_resp ^ cmp_exp) & ~cmp_mask);
  assign halt     = mismatch && sof_q;
  assign push     = (state_q == StRun) && !halt;
  assign dly_clr  = !rst_n || halt;
  assign addr_nxt = (addr_q == LastAddr) ? addr_q : addr_q + ADDR_W'(1);

  vec_chk_dly #(
    .LAT (LAT),
    .DW  (DW)
  ) u_dly (
    .clk       (clk),
    .clr       (dly_clr),
    .in_valid  (push),
    .in_data   (push_data),
    .out_valid (dly_valid),
    .out_data  (dly_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      ld_idx_q   <= '0;
      sof_q      <= 1'b0;
      stim_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_cnt_q <= '0;
      ff_idx_q   <= '0;
      ff_act_q   <= '0;
    end else begin
      if (mismatch) begin
        fail_cnt_q <= sat_inc(fail_cnt_q);
        if (fail_cnt_q == '0) begin
          ff_idx_q <= cmp_idx;
          ff_act_q <= dut_resp;
        end
      end
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            fail_cnt_q <= '0;
            ff_idx_q   <= '0;
            ff_act_q   <= '0;
            pass_q     <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
            sof_q      <= stop_on_fail;
            addr_q     <= '0;
            ld_idx_q   <= '0;
            state_q    <= StFetch;
          end
        end
        StFetch: begin
          addr_q  <= addr_nxt;
          state_q <= StRun;
        end
        StRun: begin
          if (halt) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
          end else begin
            stim_q   <= mem_stim;
            addr_q   <= addr_nxt;
            ld_idx_q <= ld_idx_q + IDX_W'(1);
            if (ld_idx_q == LastIdx) state_q <= StDrain;
          end
        end
        StDrain: begin
          // The last vector reaching the compare point means the line is empty after this edge.
          if (halt || (dly_valid && cmp_idx == LastIdx)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= !mismatch && (fail_cnt_q == '0);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_addr       = addr_q;
  assign dut_stim       = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail_cnt       = fail_cnt_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_act = ff_act_q;

endmodule

// File: tb/tb_vec_replay_chk.sv
// Bench for vec_replay_chk: latency-1 and latency-3 instances fed by a bench ROM and an
// echo DUT (resp = stim[24:0]); mask cases run only with VEC_CHK_MASK_EN defined.
module tb_vec_replay_chk;
  localparam int SW = 49;
  localparam int RW = 25;
  localparam int D  = 4;
`ifdef VEC_CHK_MASK_EN
  localparam bit MASK_ON = 1'b1;
`else
  localparam bit MASK_ON = 1'b0;
`endif

  typedef struct { int cyc; int fc; int idx; bit ps; int last; } exp_t;
  typedef struct { int k; logic [3:0] bad; bit stop; exp_t e; } vec_t;
  typedef struct {
    logic busy; logic done; logic pass; logic [15:0] fc; logic [15:0] idx;
    logic [RW-1:0] act; logic [SW-1:0] stim; logic [1:0] addr;
  } snap_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, sof_a = 1'b0, start_b = 1'b0, sof_b = 1'b0;

  logic [1:0]    mem_addr_a, mem_addr_b;
  logic [SW-1:0] mem_stim_a, mem_stim_b, dut_stim_a, dut_stim_b;
  logic [RW-1:0] mem_resp_a, mem_resp_b, dut_resp_a, dut_resp_b, pipe1, pipe2;
  logic          busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0]   fc_a, fc_b, ffi_a, ffi_b;
  logic [RW-1:0] ffa_a, ffa_b;
  logic [SW-1:0] rom_stim [D];
  logic [RW-1:0] rom_resp [D];
`ifdef VEC_CHK_MASK_EN
  logic [RW-1:0] rom_mask [D];
  logic [RW-1:0] mem_mask_a, mem_mask_b;
`endif
  int n_chk = 0;
  int n_pass = 0;

  // Synchronous ROM model and DUT models (latency 1: combinational echo; latency 3: +2 regs).
  always @(posedge clk) begin
    mem_stim_a <= rom_stim[mem_addr_a];
    mem_resp_a <= rom_resp[mem_addr_a];
    mem_stim_b <= rom_stim[mem_addr_b];
    mem_resp_b <= rom_resp[mem_addr_b];
`ifdef VEC_CHK_MASK_EN
    mem_mask_a <= rom_mask[mem_addr_a];
    mem_mask_b <= rom_mask[mem_addr_b];
`endif
    pipe1 <= dut_stim_b[RW-1:0];
    pipe2 <= pipe1;
  end
  assign dut_resp_a = dut_stim_a[RW-1:0];
  assign dut_resp_b = pipe2;

  vec_replay_chk #(.STIM_W(SW), .RESP_W(RW), .DEPTH(D), .LAT(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop_on_fail(sof_a),
    .mem_addr(mem_addr_a), .mem_stim(mem_stim_a), .mem_resp(mem_resp_a),
`ifdef VEC_CHK_MASK_EN
    .mem_mask(mem_mask_a),
`endif
    .dut_stim(dut_stim_a), .dut_resp(dut_resp_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .fail_cnt(fc_a), .first_fail_idx(ffi_a), .first_fail_act(ffa_a)
  );

  vec_replay_chk #(.STIM_W(SW), .RESP_W(RW), .DEPTH(D), .LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop_on_fail(sof_b),
    .mem_addr(mem_addr_b), .mem_stim(mem_stim_b), .mem_resp(mem_resp_b),
`ifdef VEC_CHK_MASK_EN
    .mem_mask(mem_mask_b),
`endif
    .dut_stim(dut_stim_b), .dut_resp(dut_resp_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .fail_cnt(fc_b), .first_fail_idx(ffi_b), .first_fail_act(ffa_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic snap_t snap(input int k);
    snap_t s;
    if (k == 0) s = '{busy_a, done_a, pass_a, fc_a, ffi_a, ffa_a, dut_stim_a, mem_addr_a};
    else        s = '{busy_b, done_b, pass_b, fc_b, ffi_b, ffa_b, dut_stim_b, mem_addr_b};
    return s;
  endfunction

  // Reference: outcome of a run from which vectors mismatch (eff), by the timing rules.
  function automatic exp_t model(input int lat, input logic [3:0] eff, input bit stop);
    exp_t e;
    e = '{D + lat + 1, 0, 0, 1'b1, D - 1};
    for (int i = D - 1; i >= 0; i--) if (eff[i]) begin e.idx = i; e.ps = 1'b0; end
    for (int i = 0; i < D; i++) if (eff[i]) e.fc++;
    if (stop && !e.ps) begin
      e.fc   = 1;
      e.cyc  = 2 + e.idx + lat;
      e.last = (e.idx + lat - 1 < D - 1) ? e.idx + lat - 1 : D - 1;
    end
    return e;
  endfunction

  task automatic load_rom(input logic [3:0] bad, input logic [3:0] msk);
    for (int i = 0; i < D; i++) begin
      rom_stim[i] = SW'({$urandom, $urandom});
      rom_resp[i] = rom_stim[i][RW-1:0] ^ RW'(bad[i]);
`ifdef VEC_CHK_MASK_EN
      rom_mask[i] = RW'(msk[i]);
`endif
    end
  endtask

  task automatic run(input string name, input int k, input logic [3:0] bad,
                     input logic [3:0] msk, input bit stop, input exp_t e,
                     input int poke, input bit sat);
    snap_t s;
    int    cyc;
    bit    got;
    load_rom(bad, msk);
    if (k == 0) begin start_a = 1'b1; sof_a = stop; end
    else        begin start_b = 1'b1; sof_b = stop; end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    s = snap(k);
    chk({name, "/busy_at_start"}, 64'(s.busy), 64'd1);
    chk({name, "/done_at_start"}, 64'(s.done), 64'd0);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (sat && cyc == 3) begin
        force u_dut_a.fail_cnt_q = 16'hFFFE;
        #1;
        release u_dut_a.fail_cnt_q;
      end
      if (poke > 0) begin
        if (k == 0) start_a = (cyc == poke);
        else        start_b = (cyc == poke);
      end
      s   = snap(k);
      got = s.done;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    if (!got) begin
      n_chk++;
      $display("FAIL %s/timeout: done not seen in 40 cycles, required at %0d", name, e.cyc);
    end else begin
      chk({name, "/done_cycle"}, 64'(cyc), 64'(e.cyc));
      chk({name, "/fail_cnt"}, 64'(s.fc), sat ? 64'hFFFF : 64'(e.fc));
      chk({name, "/first_idx"}, 64'(s.idx), e.ps ? 64'd0 : 64'(e.idx));
      chk({name, "/first_act"}, 64'(s.act), e.ps ? 64'd0 : 64'(rom_stim[e.idx][RW-1:0]));
      chk({name, "/pass"}, 64'(s.pass), 64'(e.ps));
      chk({name, "/busy_at_done"}, 64'(s.busy), 64'd0);
      chk({name, "/dut_stim"}, 64'(s.stim), 64'(rom_stim[e.last]));
      if (!(stop && !e.ps)) chk({name, "/mem_addr"}, 64'(s.addr), 64'(D - 1));
    end
  endtask

  task automatic chk_reset(input string name, input int k);
    snap_t s;
    s = snap(k);
    chk({name, "/busy"}, 64'(s.busy), 64'd0);
    chk({name, "/done"}, 64'(s.done), 64'd0);
    chk({name, "/pass"}, 64'(s.pass), 64'd0);
    chk({name, "/fail_cnt"}, 64'(s.fc), 64'd0);
    chk({name, "/first_idx"}, 64'(s.idx), 64'd0);
    chk({name, "/first_act"}, 64'(s.act), 64'd0);
    chk({name, "/dut_stim"}, 64'(s.stim), 64'd0);
    chk({name, "/mem_addr"}, 64'(s.addr), 64'd0);
  endtask

  initial begin
    vec_t  tbl [8];
    snap_t s;
    int    prev_k;
    tbl[0] = '{0, 4'b0000, 1'b0, '{6, 0, 0, 1'b1, 3}};
    tbl[1] = '{0, 4'b0100, 1'b0, '{6, 1, 2, 1'b0, 3}};
    tbl[2] = '{0, 4'b0100, 1'b1, '{5, 1, 2, 1'b0, 2}};
    tbl[3] = '{1, 4'b1111, 1'b0, '{8, 4, 0, 1'b0, 3}};
    tbl[4] = '{0, 4'b1000, 1'b0, '{6, 1, 3, 1'b0, 3}};
    tbl[5] = '{0, 4'b1000, 1'b1, '{6, 1, 3, 1'b0, 3}};
    tbl[6] = '{1, 4'b0010, 1'b1, '{6, 1, 1, 1'b0, 3}};
    tbl[7] = '{1, 4'b0001, 1'b1, '{5, 1, 0, 1'b0, 2}};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_a", 0);
    chk_reset("reset_b", 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      run($sformatf("tbl%0d", i), tbl[i].k, tbl[i].bad, 4'b0000, tbl[i].stop, tbl[i].e, 0, 1'b0);
    end

    run("saturate", 0, 4'b1111, 4'b0000, 1'b0, '{6, 4, 0, 1'b0, 3}, 0, 1'b1);
    run("start_while_busy", 0, 4'b0000, 4'b0000, 1'b0, '{6, 0, 0, 1'b1, 3}, 2, 1'b0);
`ifdef VEC_CHK_MASK_EN
    run("mask_hides", 0, 4'b0010, 4'b0010, 1'b0, '{6, 0, 0, 1'b1, 3}, 0, 1'b0);
    run("mask_elsewhere", 0, 4'b0010, 4'b0100, 1'b0, '{6, 1, 1, 1'b0, 3}, 0, 1'b0);
    run("mask_lat3", 1, 4'b1001, 4'b0001, 1'b1, '{8, 1, 3, 1'b0, 3}, 0, 1'b0);
`endif

    // Reset while vector 1 is on dut_stim and vector 0 has already failed.
    load_rom(4'b0001, 4'b0000);
    start_a = 1'b1;
    sof_a   = 1'b0;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    s = snap(0);
    chk("midrst/pre_stim", 64'(s.stim), 64'(rom_stim[1]));
    chk("midrst/pre_fail_cnt", 64'(s.fc), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_reset("midrst", 0);
    run("post_reset", 0, 4'b0000, 4'b0000, 1'b0, '{6, 0, 0, 1'b1, 3}, 0, 1'b0);

    prev_k = 0;
    for (int r = 0; r < 24; r++) begin
      int         k, gap;
      logic [3:0] bad, msk;
      bit         stop;
      exp_t       e;
      k    = $urandom_range(0, 1);
      bad  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
      msk  = 4'($urandom);
      stop = 1'($urandom);
      e    = model((k != 0) ? 3 : 1, MASK_ON ? (bad & ~msk) : bad, stop);
      gap  = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      if (gap > 0) begin
        s = snap(prev_k);
        chk($sformatf("rnd%0d/done_held", r), 64'(s.done), 64'd1);
      end
      run($sformatf("rnd%0d", r), k, bad, msk, stop, e, 0, 1'b0);
      prev_k = k;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
